// File: rtl/bank_burst_fsm.sv
// rtl/bank_burst_fsm.sv - DRAM bank with row activate/precharge timing, wrapped bursts and CAS read latency.
// Commands are accepted only in IDLE/ACTIVE; read beats drain through a latency pipe independent of state.
module bank_burst_fsm #(
  parameter int DEVICE_WIDTH = 4,
  parameter int COLWIDTH     = 10,
  parameter int CHWIDTH      = 5,
  parameter int BL           = 8,
  parameter int CL           = 3,
  parameter int TRCD         = 2,
  parameter int TRP          = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  input  logic [2:0]              cmd,
  input  logic [CHWIDTH-1:0]      row,
  input  logic [COLWIDTH-1:0]     column,
  input  logic [DEVICE_WIDTH-1:0] dqin,
  output logic [DEVICE_WIDTH-1:0] dqout,
  output logic                    dq_valid,
  output logic                    ready,
  output logic                    row_open,
  output logic [CHWIDTH-1:0]      open_row,
  output logic                    cmd_err
);

  localparam int LB   = $clog2(BL);
  localparam int DMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int CW   = $clog2(DMAX) + 1;
  localparam int AW   = CHWIDTH + COLWIDTH;
  localparam logic [COLWIDTH-1:0] LOW_MASK = COLWIDTH'(BL - 1);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACTIVATING,
    S_ACTIVE,
    S_BURST_RD,
    S_BURST_WR,
    S_PRECHARGING
  } state_e;

  state_e                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [LB-1:0]             beat_q, beat_d;
  logic [COLWIDTH-1:0]       col_q, col_d;
  logic [CHWIDTH-1:0]        open_row_q, open_row_d;
  logic [DEVICE_WIDTH-1:0]   mem_q [2**AW];
  logic                      pipe_vld_q [CL];
  logic [DEVICE_WIDTH-1:0]   pipe_dat_q [CL];
  logic                      dq_valid_q;
  logic [DEVICE_WIDTH-1:0]   dqout_q;

  logic                      rd_en, wr_en;
  logic [COLWIDTH-1:0]       acc_col;
  logic [LB-1:0]             acc_beat;
  logic [AW-1:0]             acc_addr;

  // Upper column bits stay fixed so the burst wraps inside its BL-aligned block.
  function automatic logic [COLWIDTH-1:0] beat_col(input logic [COLWIDTH-1:0] base,
                                                   input logic [LB-1:0] k);
    logic [COLWIDTH-1:0] sum;
    sum = base + COLWIDTH'(k);
    return (base & ~LOW_MASK) | (sum & LOW_MASK);
  endfunction

  assign ready    = (state_q == S_IDLE) || (state_q == S_ACTIVE);
  assign row_open = (state_q == S_ACTIVE) || (state_q == S_BURST_RD) || (state_q == S_BURST_WR);
  assign open_row = open_row_q;
  assign dq_valid = dq_valid_q;
  assign dqout    = dqout_q;
  assign acc_addr = {open_row_q, beat_col(acc_col, acc_beat)};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    beat_d     = beat_q;
    col_d      = col_q;
    open_row_d = open_row_q;
    cmd_err    = 1'b0;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    acc_col    = col_q;
    acc_beat   = beat_q;

    case (state_q)
      S_ACTIVATING: begin
        if (cnt_q == '0) state_d = S_ACTIVE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_PRECHARGING: begin
        if (cnt_q == '0) state_d = S_IDLE;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_BURST_RD, S_BURST_WR: begin
        rd_en = (state_q == S_BURST_RD);
        wr_en = (state_q == S_BURST_WR);
        if (beat_q == LB'(BL - 1)) state_d = S_ACTIVE;
        else                       beat_d  = beat_q + LB'(1);
      end
      default: ;
    endcase

    if (cmd_valid && cmd != CMD_NOP) begin
      if (!ready || cmd > CMD_PRE) begin
        cmd_err = 1'b1;
      end else if (state_q == S_IDLE) begin
        if (cmd == CMD_ACT) begin
          open_row_d = row;
          cnt_d      = CW'(TRCD - 1);
          state_d    = S_ACTIVATING;
        end else if (cmd == CMD_RD || cmd == CMD_WR) begin
          cmd_err = 1'b1;
        end
      end else begin
        case (cmd)
          CMD_ACT: cmd_err = 1'b1;
          CMD_RD, CMD_WR: begin
            // Beat 0 is issued on the accept edge itself.
            rd_en    = (cmd == CMD_RD);
            wr_en    = (cmd == CMD_WR);
            acc_col  = column;
            acc_beat = '0;
            col_d    = column;
            beat_d   = LB'(1);
            state_d  = (cmd == CMD_RD) ? S_BURST_RD : S_BURST_WR;
          end
          default: begin
            cnt_d   = CW'(TRP - 1);
            state_d = S_PRECHARGING;
          end
        endcase
      end
    end

    if (rst) begin
      cmd_err = 1'b0;
      rd_en   = 1'b0;
      wr_en   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      beat_q     <= '0;
      col_q      <= '0;
      open_row_q <= '0;
      dq_valid_q <= 1'b0;
      dqout_q    <= '0;
      for (int i = 0; i < CL; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_dat_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      beat_q        <= beat_d;
      col_q         <= col_d;
      open_row_q    <= open_row_d;
      pipe_vld_q[0] <= rd_en;
      pipe_dat_q[0] <= rd_en ? mem_q[acc_addr] : '0;
      for (int i = 1; i < CL; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_dat_q[i] <= pipe_dat_q[i-1];
      end
      dq_valid_q <= pipe_vld_q[CL-1];
      dqout_q    <= pipe_dat_q[CL-1];
    end
  end

  // Array is deliberately outside reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[acc_addr] <= dqin;
  end

endmodule

// File: doc/bank_burst_fsm.md
# bank_burst_fsm

Parametrised successor to the single-cycle DRAM bank model. It adds an explicit row-activation state machine, with activate/precharge delays and open-row tracking. It also adds fixed-length sequential bursts with wrap-around, and a configurable CAS read latency. It sits under the rank/chip model in place of the plain bank and is driven by the per-bank command decoder.

## Interface
- DEVICE_WIDTH, 4, data bits per beat
- COLWIDTH, 10, column address width
- CHWIDTH, 5, row address width; array is 2^CHWIDTH rows x 2^COLWIDTH columns x DEVICE_WIDTH
- BL, 8, burst length in beats; power of two, 2 ≤ BL ≤ 2^COLWIDTH
- CL, 3, read latency from RD accept edge to first data beat (≥1)
- TRCD, 2, ACT-to-ready cycles (≥1)
- TRP, 2, PRE-to-ready cycles (≥1)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present this cycle
- cmd  in  3  0=NOP, 1=ACT, 2=RD, 3=WR, 4=PRE; 5–7 illegal
- row  in  CHWIDTH  row for ACT; ignored otherwise
- column  in  COLWIDTH  start column for RD/WR
- dqin  in  DEVICE_WIDTH  write data, one beat per cycle
- dqout  out  DEVICE_WIDTH  read data; 0 when dq_valid=0
- dq_valid  out  1  dqout carries a read beat
- ready  out  1  a command is accepted this cycle if cmd_valid=1
- row_open  out  1  a row is active
- open_row  out  CHWIDTH  currently active row (holds last value when closed)
- cmd_err  out  1  one-cycle pulse: rejected command

## Operation
- States: IDLE, ACTIVATING, ACTIVE, BURST_RD, BURST_WR, PRECHARGING.
- IDLE:
  - ACT → latch row into open_row, go to ACTIVATING.
  - PRE → legal no-op.
  - RD/WR → cmd_err.
- ACTIVATING: counts TRCD cycles with ready=0, then ACTIVE with row_open=1.
- ACTIVE:
  - RD → BURST_RD.
  - WR → BURST_WR.
  - PRE → PRECHARGING, with row_open=0 from the next cycle.
  - ACT → cmd_err; the row is unchanged.
- Burst beat k (0..BL-1) address: upper column bits {column[COLWIDTH-1:log2(BL)]} held constant, low bits = (column[log2(BL)-1:0] + k) mod BL. Wrap stays inside the BL-aligned block.
- BURST_WR: dqin is written to beat 0 on the accept edge, then to beats 1..BL-1 on the next BL-1 edges. Return to ACTIVE after the last beat.
- BURST_RD: the array is read at beat k issue and pushed into a CL-deep valid/data pipeline. Return to ACTIVE after BL issue cycles.
- The read pipeline drains independently of the state. A following PRE or RD does not cancel in-flight beats.
- PRECHARGING: counts TRP cycles, then IDLE.
- Illegal cmd codes 5–7, or any cmd_valid=1 while ready=0, are ignored with cmd_err=1 for that cycle.
- NOP, or cmd_valid=0, never sets cmd_err.

## Timing
- ready=1 only in IDLE and ACTIVE. It drops the cycle after an accepted ACT, RD, WR or PRE.
- ACT accepted at edge t → ready=1 and row_open=1 at edge t+TRCD.
- RD accepted at edge t:
  - beat k appears on dqout with dq_valid=1 in the cycle after edge t+CL+k;
  - ready returns at edge t+BL, so back-to-back RDs give gapless dq_valid.
- WR accepted at edge t → beats are written at edges t..t+BL-1, and ready returns at edge t+BL. A RD accepted at t+BL sees all written beats.
- PRE accepted at edge t → ready=1 in IDLE at edge t+TRP.
- Reset values: state IDLE; ready=1, row_open=0, open_row=0, dq_valid=0, dqout=0, cmd_err=0. Counters and the read pipeline are cleared.
- Array contents are not cleared by rst.
- Reset mid-burst aborts the burst: beats already written stay, and no further dq_valid is produced.
- rst takes priority over any command in the same cycle.

## Test plan
- Reset → ready=1, row_open=0, dq_valid=0. RD in IDLE → cmd_err pulse for one cycle; state unchanged.
- ACT row=1 → ready low for 2 cycles, then row_open=1, open_row=1. WR column=0 with dqin beats 0x3,0xA,0x5,0xC,0x1,0x7,0xE,0x9 → ready low for 8 cycles. RD column=0 → the same 8 beats appear 3 cycles after accept with dq_valid high for 8 consecutive cycles.
- Wrap: RD column=6 on that row → beat order is columns 6,7,0,1,2,3,4,5, i.e. 0xE,0x9,0x3,0xA,0x5,0xC,0x1,0x7.
- Back-to-back RD column=0 then column=8 → 16 contiguous dq_valid cycles. A PRE issued right after the second RD → all 16 beats still delivered; row_open=0 and ready=1 after 2 cycles.
- cmd_valid with ACT during a burst, then cmd=6 in ACTIVE → both rejected with cmd_err; burst data unaffected.
- rst asserted at beat 3 of a WR → beats 0–2 readable after re-ACT; beats 3–7 hold old data; dq_valid=0 throughout the reset.
